alu_seq_ctrl: RTL

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 84 ++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: four-state ALU sequencer with 4x8 register file; define ALUCTRL_R0_ZERO_EN to hard-wire r0 to zero.
module alu_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ready,
  input  logic       reg_we,
  input  logic [1:0] reg_waddr,
  input  logic [7:0] reg_wdata,
  output logic [1:0] alu_ctl,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  input  logic       alu_zero,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic       res_zero,
  input  logic       res_ready
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, RESP} state_t;
  state_t     state, state_nx;
  logic [7:0] ir;
  logic [7:0] rf [4];
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  // next state and handshake flags
  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    res_valid   = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        state_nx    = instr_valid ? READ : IDLE;
      end
      READ: state_nx = EXEC;
      EXEC: state_nx = RESP;
      RESP: begin
        res_valid = 1'b1;
        state_nx  = res_ready ? IDLE : RESP;
      end
    endcase
  end
  // single register-file write port shared by preload (IDLE only) and writeback (EXEC)
  always_comb begin
    wr_en   = (state == IDLE && reg_we) || state == EXEC;
    wr_addr = state == EXEC ? ir[5:4] : reg_waddr;
    wr_data = state == EXEC ? alu_out : reg_wdata;
`ifdef ALUCTRL_R0_ZERO_EN
    if (wr_addr == 2'd0) wr_en = 1'b0;
`endif
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  // register file; r0 stays at its reset value of zero when writes to it are blocked
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)     rf <= '{default: 8'd0};
    else if (wr_en) rf[wr_addr] <= wr_data;
  // instruction capture, operand fetch and result capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ir       <= '0;
      alu_ctl  <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      res_data <= '0;
      res_zero <= 1'b0;
    end else begin
      if (state == IDLE && instr_valid) ir <= instr;
      if (state == READ) begin
        alu_ctl <= ir[7:6];
        alu_a   <= rf[ir[3:2]];
        alu_b   <= rf[ir[1:0]];
      end
      if (state == EXEC) begin
        res_data <= alu_out;
        res_zero <= alu_zero;
      end
    end
endmodule
